wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Write-back arbiter that owns the single register-file write port (we/waddr/wdata).
- Merges two result sources:
  - the in-order pipeline result from MEM, one per cycle, with no backpressure;
  - a long-latency unit result (divider/load miss), delivered by valid/ready handshake and buffered in a small FIFO.
- Sits between MEM and the register file, replacing the plain MEM/WB register.
- Guarantees forward progress for buffered results by requesting a one-cycle pipeline stall.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width (32 registers).
- FIFO_DEPTH, 2, aux result buffer entries (power of 2, ≥2).
- STARVE_MAX, 4, cycles a non-empty FIFO may wait before a forced drain.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- mem_we  in  1  pipeline result write enable.
- mem_waddr  in  ADDR_W  pipeline destination register.
- mem_wdata  in  DATA_W  pipeline result data.
- aux_valid  in  1  long-latency result valid.
- aux_ready  out  1  FIFO can accept (registered: count<FIFO_DEPTH).
- aux_waddr  in  ADDR_W  long-latency destination.
- aux_wdata  in  DATA_W  long-latency data.
- wb_we  out  1  to register file write enable (registered).
- wb_waddr  out  ADDR_W  to register file write address (registered).
- wb_wdata  out  DATA_W  to register file write data (registered).
- stall_req  out  1  pipeline hold request (registered; high only in FORCE).
- fifo_count  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (sync, rst=1 at posedge):
  - wb_we=0, wb_waddr=0, wb_wdata=0, stall_req=0.
  - FIFO empty (fifo_count=0, aux_ready=1).
  - starve counter=0, state=NORMAL.
  - Reset mid-operation discards buffered entries; no write issued that cycle.
- Pipe slot:
  - pipe_v = mem_we && mem_waddr!=0 && state==NORMAL.
  - While stall_req=1, MEM holds its inputs stable; they are consumed the following cycle.
- Aux push:
  - Occurs on aux_valid && aux_ready at posedge.
  - aux_waddr==0 is accepted (handshake completes) but not enqueued.
  - aux_ready depends only on registered count. A full FIFO does not accept even if it pops in the same cycle.
- State NORMAL, per posedge:
  - If pipe_v: wb_* ← mem_*, wb_we=1. No pop.
  - Else if FIFO non-empty: wb_* ← FIFO head, wb_we=1, pop.
  - Else wb_we=0; wb_waddr and wb_wdata hold their last values.
- Latency: one cycle from input to wb_* for pipe; at least one cycle from push to write for aux. An empty-FIFO push is not written in the push cycle.
- Starve counter:
  - Increments each NORMAL cycle where the FIFO is non-empty and no pop occurs. Clears on pop or when empty.
  - When counter==STARVE_MAX-1 and the condition holds again: state→FORCE, stall_req→1, counter→0.
- State FORCE (exactly one cycle):
  - FIFO head written (wb_we=1) and popped; mem_* ignored.
  - Next: state→NORMAL, stall_req→0.
- Ordering (WAW): when a pipe write commits with address A, every valid FIFO entry with waddr==A is invalidated. The pipe result is younger.
  - Invalidated entries are skipped without consuming a write cycle; count decrements.
  - This also applies to an entry pushed in the same cycle with matching address: it is not enqueued.
- Simultaneous push+pop keeps count unchanged.
- Pointer wrap-around is modulo FIFO_DEPTH.
- Register-file semantics (reads see wdata when we=1) are unaffected. wb_* drive the write port directly.

Test Plan:
- Reset, then mem_we=1, waddr=5, wdata=0xDEADBEEF -> next edge wb_we=1, wb_waddr=5, wb_wdata=0xDEADBEEF; stall_req=0 throughout.
- Idle pipe (mem_we=0), aux push waddr=7, data=0x12 -> fifo_count=1, then next edge wb_we=1, waddr=7, data=0x12, fifo_count=0.
- Two aux pushes (waddr 3 and 4) -> aux_ready=0 at count=2, third aux_valid held until a pop; entries written in order 3 then 4.
- One aux entry (waddr=9) with continuous pipe writes to waddr=1 -> after 4 starved cycles stall_req=1 for one cycle, wb_waddr=9 written, mem_* for the held instruction written the next cycle.
- Aux entry waddr=6 buffered, pipe writes waddr=6, data=0xAA -> FIFO entry dropped, only 0xAA reaches reg 6, fifo_count=0.
- Assert rst with fifo_count=2 and state FORCE -> next edge all outputs 0, aux_ready=1, no aux write ever issued.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Write-back arbiter bus: MEM result, long-latency handshake, RF write port.
// master = arbiter side, slave = pipeline / aux unit / register file side.
interface wb_arbiter_if #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              aux_valid;
    logic              aux_ready;
    logic [ADDR_W-1:0] aux_waddr;
    logic [DATA_W-1:0] aux_wdata;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_waddr;
    logic [DATA_W-1:0] wb_wdata;
    logic              stall_req;
    logic [CNT_W-1:0]  fifo_count;

    modport master (
        input  mem_we, mem_waddr, mem_wdata,
        input  aux_valid, aux_waddr, aux_wdata,
        output aux_ready,
        output wb_we, wb_waddr, wb_wdata,
        output stall_req, fifo_count
    );

    modport slave (
        output mem_we, mem_waddr, mem_wdata,
        output aux_valid, aux_waddr, aux_wdata,
        input  aux_ready,
        input  wb_we, wb_waddr, wb_wdata,
        input  stall_req, fifo_count
    );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges MEM results and buffered long-latency results
// onto the single RF write port. Ports: clk, rst (sync, high), bus (master).
module wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    wb_arbiter_if.master  bus
);
    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam int SW    = $clog2(STARVE_MAX + 1);

    typedef enum logic {NORMAL, FORCE} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] q_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] q_data [FIFO_DEPTH];
    logic [ADDR_W-1:0] qa_n   [FIFO_DEPTH];
    logic [DATA_W-1:0] qd_n   [FIFO_DEPTH];
    logic [CNT_W-1:0]  cnt, cnt_n, kept;
    logic [SW-1:0]     starve, starve_n;
    logic              ready, pipe_v, pop, push, keep, starving;

    assign ready          = (cnt < CNT_W'(FIFO_DEPTH));
    assign bus.aux_ready  = ready;
    assign bus.fifo_count = cnt;

    assign pipe_v = (state == NORMAL) && bus.mem_we &&
                    (bus.mem_waddr != '0);
    assign pop    = (cnt != '0) && ((state == FORCE) || !pipe_v);
    // A same-cycle pipe write to the same register makes the aux result stale.
    assign push   = bus.aux_valid && ready && (bus.aux_waddr != '0) &&
                    !(pipe_v && (bus.aux_waddr == bus.mem_waddr));

    // FIFO is kept compacted: entry 0 is the head. Popped and WAW-killed
    // entries are squeezed out, so count always equals live entries.
    always_comb begin
        cnt_n = '0;
        kept  = '0;
        keep  = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            qa_n[i] = '0;
            qd_n[i] = '0;
        end
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            keep = (CNT_W'(i) < cnt) && !(pop && (i == 0)) &&
                   !(pipe_v && (q_addr[i] == bus.mem_waddr));
            if (keep) begin
                qa_n[cnt_n[IDX_W-1:0]] = q_addr[i];
                qd_n[cnt_n[IDX_W-1:0]] = q_data[i];
                cnt_n = cnt_n + CNT_W'(1);
            end
        end
        kept = cnt_n;
        if (push) begin
            qa_n[cnt_n[IDX_W-1:0]] = bus.aux_waddr;
            qd_n[cnt_n[IDX_W-1:0]] = bus.aux_wdata;
            cnt_n = cnt_n + CNT_W'(1);
        end
    end

    // Starvation counts only surviving old entries that were not drained.
    assign starving = (state == NORMAL) && (kept != '0) && !pop;

    always_comb begin
        state_n  = NORMAL;
        starve_n = '0;
        if (starving) begin
            if (starve == SW'(STARVE_MAX - 1)) begin
                state_n = FORCE;
            end else begin
                starve_n = starve + SW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= NORMAL;
            starve <= '0;
        end else begin
            state  <= state_n;
            starve <= starve_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_n;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            q_addr[i] <= qa_n[i];
            q_data[i] <= qd_n[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.wb_we     <= 1'b0;
            bus.wb_waddr  <= '0;
            bus.wb_wdata  <= '0;
            bus.stall_req <= 1'b0;
        end else begin
            bus.wb_we     <= pipe_v || pop;
            bus.stall_req <= (state_n == FORCE);
            if (pipe_v) begin
                bus.wb_waddr <= bus.mem_waddr;
                bus.wb_wdata <= bus.mem_wdata;
            end else if (pop) begin
                bus.wb_waddr <= q_addr[0];
                bus.wb_wdata <= q_data[0];
            end
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: queue-based reference model, directed
// scenarios then randomized traffic with resets.
module tb_wb_arbiter;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int FIFO_DEPTH = 2;
    localparam int STARVE_MAX = 4;
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_arbiter_if #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) bus ();

    wb_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W),
        .FIFO_DEPTH(FIFO_DEPTH), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              stall;
        logic [CNT_W-1:0]  cnt;
        logic              rdy;
    } exp_t;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    exp_t sb [$];
    ent_t mq [$];
    int   m_starve;
    bit   m_force;
    bit   m_we;
    bit   m_stall;
    logic [ADDR_W-1:0] m_a;
    logic [DATA_W-1:0] m_d;

    bit                h_we;
    logic [ADDR_W-1:0] h_a;
    logic [DATA_W-1:0] h_d;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference: result order from the spec rules, FIFO as a plain queue.
    task automatic model(input bit r, input bit mwe,
                         input logic [ADDR_W-1:0] ma,
                         input logic [DATA_W-1:0] md, input bit av,
                         input logic [ADDR_W-1:0] aa,
                         input logic [DATA_W-1:0] ad);
        bit   pipe, popd, rdy;
        ent_t t [$];
        ent_t e;
        if (r) begin
            mq = {};
            m_starve = 0;
            m_force = 0;
            m_we = 0;
            m_a = '0;
            m_d = '0;
            m_stall = 0;
            return;
        end
        rdy  = mq.size() < FIFO_DEPTH;
        pipe = !m_force && mwe && (ma != 0);
        popd = 0;
        if (pipe) begin
            m_we = 1;
            m_a = ma;
            m_d = md;
            t = {};
            foreach (mq[i]) if (mq[i].a != ma) t.push_back(mq[i]);
            mq = t;
        end else if (mq.size() > 0) begin
            m_we = 1;
            m_a = mq[0].a;
            m_d = mq[0].d;
            void'(mq.pop_front());
            popd = 1;
        end else begin
            m_we = 0;
        end
        if (m_force) begin
            m_force = 0;
            m_starve = 0;
        end else if (!popd && mq.size() > 0) begin
            if (m_starve == STARVE_MAX - 1) begin
                m_force = 1;
                m_starve = 0;
            end else begin
                m_starve++;
            end
        end else begin
            m_starve = 0;
        end
        if (av && rdy && aa != 0 && !(pipe && aa == ma)) begin
            e.a = aa;
            e.d = ad;
            mq.push_back(e);
        end
        m_stall = m_force;
    endtask

    task automatic cyc(input bit r, input bit mwe,
                       input logic [ADDR_W-1:0] ma,
                       input logic [DATA_W-1:0] md, input bit av,
                       input logic [ADDR_W-1:0] aa,
                       input logic [DATA_W-1:0] ad, output bit acc);
        exp_t x;
        @(negedge clk);
        if (m_stall && !r) begin
            mwe = h_we;
            ma  = h_a;
            md  = h_d;
        end
        h_we = mwe;
        h_a  = ma;
        h_d  = md;
        rst = r;
        bus.mem_we    = mwe;
        bus.mem_waddr = ma;
        bus.mem_wdata = md;
        bus.aux_valid = av;
        bus.aux_waddr = aa;
        bus.aux_wdata = ad;
        acc = !r && av && (mq.size() < FIFO_DEPTH);
        model(r, mwe, ma, md, av, aa, ad);
        x.we    = m_we;
        x.a     = m_a;
        x.d     = m_d;
        x.stall = m_stall;
        x.cnt   = CNT_W'(mq.size());
        x.rdy   = mq.size() < FIFO_DEPTH;
        sb.push_back(x);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, acc);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("wb_we", 32'(bus.wb_we), 32'(e.we));
                chk("wb_waddr", 32'(bus.wb_waddr), 32'(e.a));
                chk("wb_wdata", bus.wb_wdata, e.d);
                chk("stall_req", 32'(bus.stall_req), 32'(e.stall));
                chk("fifo_count", 32'(bus.fifo_count), 32'(e.cnt));
                chk("aux_ready", 32'(bus.aux_ready), 32'(e.rdy));
            end
        end
    end

    initial begin
        bit acc;
        bit pv;
        int k;
        logic [ADDR_W-1:0] pa;
        logic [DATA_W-1:0] pd;
        bus.mem_we = 0;
        bus.mem_waddr = '0;
        bus.mem_wdata = '0;
        bus.aux_valid = 0;
        bus.aux_waddr = '0;
        bus.aux_wdata = '0;
        m_stall = 0;

        cyc(1, 0, 0, 0, 0, 0, 0, acc);
        cyc(1, 0, 0, 0, 0, 0, 0, acc);
        idle(1);

        cyc(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, acc);
        idle(2);

        cyc(0, 0, 0, 0, 1, 7, 32'h12, acc);
        idle(3);

        cyc(0, 1, 10, 32'hA0, 1, 3, 32'h33, acc);
        cyc(0, 1, 11, 32'hA1, 1, 4, 32'h44, acc);
        k = 0;
        do begin
            cyc(0, 0, 0, 0, 1, 8, 32'h88, acc);
            k++;
        end while (!acc && k < 20);
        chk("aux_hold_bound", 32'(acc), 32'd1);
        idle(4);

        cyc(0, 0, 0, 0, 1, 9, 32'h99, acc);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 1, 32'h100 + 32'(i), 0, 0, 0, acc);
        end
        idle(3);

        cyc(0, 0, 0, 0, 1, 6, 32'h66, acc);
        cyc(0, 1, 6, 32'hAA, 0, 0, 0, acc);
        idle(3);

        cyc(0, 1, 12, 32'hB0, 1, 3, 32'h33, acc);
        cyc(0, 1, 13, 32'hB1, 1, 4, 32'h44, acc);
        k = 0;
        while (!m_force && k < 10) begin
            cyc(0, 1, 14, 32'hC0 + 32'(k), 0, 0, 0, acc);
            k++;
        end
        chk("force_bound", 32'(m_force), 32'd1);
        cyc(1, 1, 14, 32'hCC, 0, 0, 0, acc);
        idle(4);

        pv = 0;
        pa = '0;
        pd = '0;
        for (int i = 0; i < 1500; i++) begin
            if (!pv && $urandom_range(0, 9) < 4) begin
                pv = 1;
                pa = ADDR_W'($urandom_range(0, 7));
                pd = $urandom;
            end
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 9) < 7),
                ADDR_W'($urandom_range(0, 7)), $urandom,
                pv, pa, pd, acc);
            if (acc) pv = 0;
        end
        idle(2);

        @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
